mmss_bcd_counter: RTL

Minutes:seconds BCD time counter that feeds the four-digit seven-segment display stage with min_ten/min_one/sec_ten/sec_one.
Runs entirely on the system clock, with single-cycle tick enables instead of divided clocks.
Handles run/pause toggling, a field-adjust mode, up/down counting and a rollover flag.
Sits between the debouncers/tick generators and the display multiplexer.

---
 rtl/clock_sim_pkg.sv | 19 +
 rtl/bcd_mod_counter.sv | 66 ++++++
 rtl/mmss_bcd_counter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/clock_sim_pkg.sv
// Shared types and constants for the mm:ss BCD time counter.
package clock_sim_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        ADJUST = 2'd2
    } state_t;

    localparam int SEC_MAX = 59;

    // Packs a 0..99 binary value as two BCD digits {tens, ones}.
    function automatic logic [7:0] to_bcd2(input int v);
        to_bcd2 = {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping between 00 and modulus (BCD), up or down.
// Digits update one cycle after en; wrap is combinational so it can enable the next field in the same cycle.
module bcd_mod_counter
    import clock_sim_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       dir,
    input  logic       carry_in_mode,
    input  logic [7:0] modulus,
    output bcd_t       ten,
    output bcd_t       one,
    output logic       wrap
);

    logic [7:0] val;
    logic       at_top;
    logic       at_bot;
    logic       down;
    bcd_t       ten_nxt;
    bcd_t       one_nxt;

    // carry_in_mode = 0 is an adjust step: increment only, never report a wrap.
    assign val    = {ten, one};
    assign at_top = (val >= modulus);
    assign at_bot = (val == 8'h00);
    assign down   = dir & carry_in_mode;
    assign wrap   = en & carry_in_mode & (down ? at_bot : at_top);

    always_comb begin
        ten_nxt = ten;
        one_nxt = one;
        if (down) begin
            if (at_bot) begin
                {ten_nxt, one_nxt} = modulus;
            end else if (one == 4'd0) begin
                one_nxt = 4'd9;
                ten_nxt = ten - 4'd1;
            end else begin
                one_nxt = one - 4'd1;
            end
        end else begin
            if (at_top) begin
                ten_nxt = 4'd0;
                one_nxt = 4'd0;
            end else if (one >= 4'd9) begin
                one_nxt = 4'd0;
                ten_nxt = ten + 4'd1;
            end else begin
                one_nxt = one + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ten <= 4'd0;
            one <= 4'd0;
        end else if (en) begin
            ten <= ten_nxt;
            one <= one_nxt;
        end
    end

endmodule

// File: rtl/mmss_bcd_counter.sv
// mm:ss BCD counter with run/pause, field adjust, up/down and rollover pulse; MMSS_ZERO_STOP_EN stops a down-count at 00:00.
// All outputs registered, one cycle after the qualifying tick; no backpressure, ticks are single-cycle enables.
module mmss_bcd_counter
    import clock_sim_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick_1hz,
    input  logic tick_adj,
    input  logic pause_btn,
    input  logic adjust_en,
    input  logic adjust_sel,
    input  logic count_down,
    output bcd_t min_ten,
    output bcd_t min_one,
    output bcd_t sec_ten,
    output bcd_t sec_one,
    output logic running,
    output logic rollover
);

    localparam logic [7:0] SEC_MOD = to_bcd2(SEC_MAX);
    localparam logic [7:0] MIN_MOD = to_bcd2(MAX_MIN);

    state_t state;
    state_t state_nxt;
    state_t saved_state;
    state_t saved_nxt;
    logic   pause_q;
    logic   toggle;
    logic   cnt_step;
    logic   adj_step;
    logic   at_zero;
    logic   zero_stop;
    logic   sec_en;
    logic   min_en;
    logic   sec_wrap;
    logic   min_wrap;

    assign toggle   = pause_btn & ~pause_q;
    assign cnt_step = tick_1hz & (state == RUN);
    assign adj_step = tick_adj & (state == ADJUST);
    assign at_zero  = ({min_ten, min_one, sec_ten, sec_one} == 16'h0000);

`ifdef MMSS_ZERO_STOP_EN
    assign zero_stop = cnt_step & count_down & at_zero;
`else
    assign zero_stop = 1'b0;
`endif

    // Minutes follow the seconds wrap when counting, but are stepped directly when adjusting.
    assign sec_en = (cnt_step & ~zero_stop) | (adj_step & adjust_sel);
    assign min_en = (cnt_step & sec_wrap) | (adj_step & ~adjust_sel);

    bcd_mod_counter u_sec (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (sec_en),
        .dir           (count_down),
        .carry_in_mode (cnt_step),
        .modulus       (SEC_MOD),
        .ten           (sec_ten),
        .one           (sec_one),
        .wrap          (sec_wrap)
    );

    bcd_mod_counter u_min (
        .clk           (clk),
        .reset_n       (reset_n),
        .en            (min_en),
        .dir           (count_down),
        .carry_in_mode (cnt_step),
        .modulus       (MIN_MOD),
        .ten           (min_ten),
        .one           (min_one),
        .wrap          (min_wrap)
    );

    // Unknown encodings fall into the default arm and behave exactly like PAUSED.
    always_comb begin
        state_nxt = state;
        saved_nxt = saved_state;
        case (state)
            RUN: begin
                if (adjust_en) begin
                    state_nxt = ADJUST;
                    saved_nxt = zero_stop ? PAUSED : RUN;
                end else if (zero_stop || toggle) begin
                    state_nxt = PAUSED;
                end
            end
            ADJUST: begin
                if (!adjust_en) begin
                    state_nxt = saved_state;
                end
            end
            default: begin
                if (adjust_en) begin
                    state_nxt = ADJUST;
                    saved_nxt = PAUSED;
                end else if (toggle) begin
                    state_nxt = RUN;
                end
            end
        endcase
    end

    assign running = (state == RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            saved_state <= RUN;
            pause_q     <= 1'b0;
            rollover    <= 1'b0;
        end else begin
            state       <= state_nxt;
            saved_state <= saved_nxt;
            pause_q     <= pause_btn;
            rollover    <= min_wrap | zero_stop;
        end
    end

endmodule
